// File: rtl/sad_disparity_engine_pkg.sv
// Shared types and elaboration-time helpers for the SAD stereo disparity engine.
// Package sad_pkg: window cost width, engine state encoding, depth table entries.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        EMIT   = 2'd2
    } sad_state_e;

    // Bits needed to hold kernel_width^2 absolute differences without overflow.
    function automatic int cost_w(input int kernel_width, input int pixel_w);
        return pixel_w + $clog2(kernel_width * kernel_width);
    endfunction

    // One entry of the disparity-to-depth table, floor of d*255/max_disparity.
    function automatic logic [7:0] depth_entry(input int d, input int max_disparity);
        int scaled;
        scaled = (d * 32'sd255) / max_disparity;
        return scaled[7:0];
    endfunction

endpackage

// File: rtl/sad_disparity_engine_if.sv
// Column-in / depth-out bus of the SAD disparity engine.
// cost_out exists only when SAD_COST_OUT_EN is defined.
interface sad_disparity_engine_if #(
    parameter int KERNEL_WIDTH = 3,
    parameter int PIXEL_W      = 8,
    parameter int HCOUNT_W     = 10,
    parameter int VCOUNT_W     = 9
);
    import sad_pkg::*;

    logic [KERNEL_WIDTH*PIXEL_W-1:0] left_data_in;
    logic [KERNEL_WIDTH*PIXEL_W-1:0] right_data_in;
    logic [HCOUNT_W-1:0]             hcount_in;
    logic [VCOUNT_W-1:0]             vcount_in;
    logic                            data_valid_in;
    logic                            ready_out;
    logic                            data_valid_out;
    logic [HCOUNT_W-1:0]             hcount_out;
    logic [VCOUNT_W-1:0]             vcount_out;
    logic [7:0]                      line_out;
    logic                            warmup_out;
`ifdef SAD_COST_OUT_EN
    localparam int COST_W = cost_w(KERNEL_WIDTH, PIXEL_W);
    logic [COST_W-1:0]               cost_out;
`endif

    modport slave (
`ifdef SAD_COST_OUT_EN
        output cost_out,
`endif
        input  left_data_in, right_data_in, hcount_in, vcount_in, data_valid_in,
        output ready_out, data_valid_out, hcount_out, vcount_out, line_out, warmup_out
    );

    modport master (
`ifdef SAD_COST_OUT_EN
        input  cost_out,
`endif
        output left_data_in, right_data_in, hcount_in, vcount_in, data_valid_in,
        input  ready_out, data_valid_out, hcount_out, vcount_out, line_out, warmup_out
    );

endinterface

// File: rtl/sad_disparity_engine_window_cost.sv
// Combinational sum of absolute differences over a KERNEL_WIDTH x KERNEL_WIDTH window pair.
module sad_window_cost
    import sad_pkg::*;
#(
    parameter int  KERNEL_WIDTH = 3,
    parameter int  PIXEL_W      = 8,
    localparam int COST_W       = cost_w(KERNEL_WIDTH, PIXEL_W)
) (
    input  logic [PIXEL_W-1:0] left_win  [KERNEL_WIDTH][KERNEL_WIDTH],
    input  logic [PIXEL_W-1:0] right_win [KERNEL_WIDTH][KERNEL_WIDTH],
    output logic [COST_W-1:0]  cost
);

    logic [PIXEL_W-1:0] diff_s;
    logic [COST_W-1:0]  sum_s;

    // Unsigned |a-b| per pixel, accumulated at full cost width.
    always_comb begin
        diff_s = '0;
        sum_s  = '0;
        for (int c = 0; c < KERNEL_WIDTH; c++) begin
            for (int r = 0; r < KERNEL_WIDTH; r++) begin
                diff_s = (left_win[c][r] > right_win[c][r]) ?
                         (left_win[c][r] - right_win[c][r]) :
                         (right_win[c][r] - left_win[c][r]);
                sum_s  = sum_s + COST_W'(diff_s);
            end
        end
    end

    assign cost = sum_s;

endmodule

// File: rtl/sad_disparity_engine.sv
// Streaming SAD block-matching engine: one column in, disparities 0..MAX_DISPARITY searched, one depth out.
// Define SAD_COST_OUT_EN to expose the winning cost on cost_out.
module sad_disparity_engine
    import sad_pkg::*;
#(
    parameter int KERNEL_WIDTH  = 3,
    parameter int MAX_DISPARITY = 10,
    parameter int PIXEL_W       = 8,
    parameter int HCOUNT_W      = 10,
    parameter int VCOUNT_W      = 9
) (
    input logic                   clk_in,
    input logic                   rst_in,
    sad_disparity_engine_if.slave bus
);

    localparam int COST_W     = cost_w(KERNEL_WIDTH, PIXEL_W);
    localparam int RIGHT_COLS = KERNEL_WIDTH + MAX_DISPARITY;
    localparam int D_W        = $clog2(MAX_DISPARITY + 1);
    localparam int IDX_W      = $clog2(RIGHT_COLS);
    localparam int CNT_W      = $clog2(RIGHT_COLS + 1);

    sad_state_e          state_r, state_next_s;
    logic [PIXEL_W-1:0]  left_cache_r  [KERNEL_WIDTH][KERNEL_WIDTH];
    logic [PIXEL_W-1:0]  right_cache_r [RIGHT_COLS][KERNEL_WIDTH];
    logic [PIXEL_W-1:0]  left_col_s    [KERNEL_WIDTH];
    logic [PIXEL_W-1:0]  right_col_s   [KERNEL_WIDTH];
    logic [PIXEL_W-1:0]  right_win_s   [KERNEL_WIDTH][KERNEL_WIDTH];
    logic [D_W-1:0]      d_r, best_d_r, best_d_next_s;
    logic [COST_W-1:0]   best_cost_r, best_cost_next_s, cost_s;
    logic [CNT_W-1:0]    col_cnt_r, col_cnt_next_s;
    logic [HCOUNT_W-1:0] hcount_r, hcount_out_r;
    logic [VCOUNT_W-1:0] vcount_r, vcount_out_r;
    logic [7:0]          line_out_r;
    logic                warm_r, warmup_out_r, valid_out_r, ready_r;
    logic                accept_s, row_start_s, last_cand_s, load_out_s;
    logic [7:0]          depth_lut_s [MAX_DISPARITY+1];

    for (genvar gi = 0; gi <= MAX_DISPARITY; gi++) begin : g_depth_lut
        assign depth_lut_s[gi] = depth_entry(gi, MAX_DISPARITY);
    end

    // Unpack the incoming columns (element 0 = top row in the low bits) and slice the right cache at d.
    always_comb begin
        for (int r = 0; r < KERNEL_WIDTH; r++) begin
            left_col_s[r]  = bus.left_data_in[r*PIXEL_W +: PIXEL_W];
            right_col_s[r] = bus.right_data_in[r*PIXEL_W +: PIXEL_W];
        end
        for (int c = 0; c < KERNEL_WIDTH; c++) begin
            for (int r = 0; r < KERNEL_WIDTH; r++) begin
                right_win_s[c][r] = right_cache_r[IDX_W'(c) + IDX_W'(d_r)][r];
            end
        end
    end

    sad_window_cost #(
        .KERNEL_WIDTH (KERNEL_WIDTH),
        .PIXEL_W      (PIXEL_W)
    ) u_window_cost (
        .left_win  (left_cache_r),
        .right_win (right_win_s),
        .cost      (cost_s)
    );

    // Handshake, row bookkeeping and running best-match selection.
    always_comb begin
        accept_s         = 1'b0;
        row_start_s      = 1'b0;
        col_cnt_next_s   = col_cnt_r;
        last_cand_s      = 1'b0;
        best_cost_next_s = best_cost_r;
        best_d_next_s    = best_d_r;
        accept_s    = bus.data_valid_in && ready_r && (state_r == IDLE);
        row_start_s = (bus.hcount_in == '0);
        last_cand_s = (d_r == D_W'(MAX_DISPARITY));
        if (row_start_s) begin
            col_cnt_next_s = CNT_W'(1);
        end else if (col_cnt_r < CNT_W'(RIGHT_COLS)) begin
            col_cnt_next_s = col_cnt_r + CNT_W'(1);
        end else begin
            col_cnt_next_s = col_cnt_r;
        end
        // Strict compare: ties keep the smaller disparity found earlier.
        if (cost_s < best_cost_r) begin
            best_cost_next_s = cost_s;
            best_d_next_s    = d_r;
        end else begin
            best_cost_next_s = best_cost_r;
            best_d_next_s    = best_d_r;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        load_out_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = SEARCH;
                else          state_next_s = IDLE;
            end
            SEARCH: begin
                if (last_cand_s) begin
                    state_next_s = EMIT;
                    load_out_s   = 1'b1;
                end else begin
                    state_next_s = SEARCH;
                end
            end
            EMIT:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register and registered ready.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == IDLE);
        end
    end

    // Column caches: shift on accept, zero the history at a row start.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int c = 0; c < KERNEL_WIDTH; c++)
                for (int r = 0; r < KERNEL_WIDTH; r++) left_cache_r[c][r] <= '0;
            for (int c = 0; c < RIGHT_COLS; c++)
                for (int r = 0; r < KERNEL_WIDTH; r++) right_cache_r[c][r] <= '0;
        end else if (accept_s) begin
            for (int r = 0; r < KERNEL_WIDTH; r++) begin
                left_cache_r[0][r]  <= left_col_s[r];
                right_cache_r[0][r] <= right_col_s[r];
            end
            for (int c = 1; c < KERNEL_WIDTH; c++)
                for (int r = 0; r < KERNEL_WIDTH; r++)
                    left_cache_r[c][r] <= row_start_s ? '0 : left_cache_r[c-1][r];
            for (int c = 1; c < RIGHT_COLS; c++)
                for (int r = 0; r < KERNEL_WIDTH; r++)
                    right_cache_r[c][r] <= row_start_s ? '0 : right_cache_r[c-1][r];
        end
    end

    // Search state: candidate index, best match, row column counter, captured coordinates.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            d_r         <= '0;
            best_d_r    <= '0;
            best_cost_r <= '0;
            col_cnt_r   <= '0;
            warm_r      <= 1'b0;
            hcount_r    <= '0;
            vcount_r    <= '0;
        end else if (accept_s) begin
            d_r         <= '0;
            best_d_r    <= '0;
            best_cost_r <= '1;
            col_cnt_r   <= col_cnt_next_s;
            warm_r      <= (col_cnt_next_s < CNT_W'(RIGHT_COLS));
            hcount_r    <= bus.hcount_in;
            vcount_r    <= bus.vcount_in;
        end else if (state_r == SEARCH) begin
            best_d_r    <= best_d_next_s;
            best_cost_r <= best_cost_next_s;
            if (!last_cand_s) d_r <= d_r + D_W'(1);
        end
    end

    // Result registers: loaded on the final candidate so they are valid during EMIT, held afterwards.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_out_r  <= 1'b0;
            line_out_r   <= '0;
            hcount_out_r <= '0;
            vcount_out_r <= '0;
            warmup_out_r <= 1'b0;
        end else begin
            valid_out_r <= load_out_s;
            if (load_out_s) begin
                line_out_r   <= depth_lut_s[best_d_next_s];
                hcount_out_r <= hcount_r;
                vcount_out_r <= vcount_r;
                warmup_out_r <= warm_r;
            end
        end
    end

`ifdef SAD_COST_OUT_EN
    logic [COST_W-1:0] cost_out_r;

    // Winning cost, updated alongside the other result registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cost_out_r <= '0;
        end else if (load_out_s) begin
            cost_out_r <= best_cost_next_s;
        end
    end

    assign bus.cost_out = cost_out_r;
`endif

    assign bus.ready_out      = ready_r;
    assign bus.data_valid_out = valid_out_r;
    assign bus.line_out       = line_out_r;
    assign bus.hcount_out     = hcount_out_r;
    assign bus.vcount_out     = vcount_out_r;
    assign bus.warmup_out     = warmup_out_r;

endmodule

// File: tb/tb_sad_disparity_engine.sv
// Directed bench for sad_disparity_engine; cost_out checks are compiled in with SAD_COST_OUT_EN.
module tb_sad_disparity_engine;

    localparam int KW = 3;
    localparam int MD = 10;
    localparam int PW = 8;
    localparam int HW = 10;
    localparam int VW = 9;
    localparam int CW = PW + $clog2(KW * KW);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sad_disparity_engine_if #(.KERNEL_WIDTH(KW), .PIXEL_W(PW), .HCOUNT_W(HW), .VCOUNT_W(VW)) bus ();

    sad_disparity_engine #(
        .KERNEL_WIDTH(KW), .MAX_DISPARITY(MD), .PIXEL_W(PW), .HCOUNT_W(HW), .VCOUNT_W(VW)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;
    logic [7:0]    res_line;
    logic          res_warm;
    logic [HW-1:0] res_h;
    logic [VW-1:0] res_v;
    logic [CW-1:0] res_cost;
    logic          res_got;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] tex(input int x, input int r);
        int v;
        v = (x * 53 + r * 97 + x * x * 11 + 17) % 256;
        return v[7:0];
    endfunction

    function automatic logic [KW*PW-1:0] tex_col(input int x);
        return {tex(x, 2), tex(x, 1), tex(x, 0)};
    endfunction

    function automatic logic [KW*PW-1:0] flat_col(input logic [7:0] p);
        return {p, p, p};
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_out) break;
            tick();
        end
    endtask

    // Offer one column, then wait (bounded) for its result pulse and capture the outputs.
    task automatic send_col(input logic [KW*PW-1:0] l, input logic [KW*PW-1:0] r,
                            input int h, input int v);
        wait_ready();
        bus.left_data_in  = l;
        bus.right_data_in = r;
        bus.hcount_in     = HW'(h);
        bus.vcount_in     = VW'(v);
        bus.data_valid_in = 1'b1;
        tick();
        bus.data_valid_in = 1'b0;
        res_got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.data_valid_out) begin
                res_got  = 1'b1;
                res_line = bus.line_out;
                res_warm = bus.warmup_out;
                res_h    = bus.hcount_out;
                res_v    = bus.vcount_out;
`ifdef SAD_COST_OUT_EN
                res_cost = bus.cost_out;
`else
                res_cost = '0;
`endif
                break;
            end
            tick();
        end
        check_val("dv_seen", 32'(res_got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.left_data_in  = '0;
        bus.right_data_in = '0;
        bus.hcount_in     = '0;
        bus.vcount_in     = '0;
        bus.data_valid_in = 1'b0;

        // Reset held three cycles with a column offered mid-reset.
        tick();
        bus.left_data_in  = flat_col(8'd50);
        bus.right_data_in = flat_col(8'd60);
        bus.hcount_in     = 10'd5;
        bus.data_valid_in = 1'b1;
        tick();
        bus.data_valid_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_val("rst_ready", 32'(bus.ready_out), 32'd1);
        check_val("rst_dv", 32'(bus.data_valid_out), 32'd0);
        check_val("rst_line", 32'(bus.line_out), 32'd0);
        check_val("rst_hcount", 32'(bus.hcount_out), 32'd0);
        check_val("rst_vcount", 32'(bus.vcount_out), 32'd0);
        check_val("rst_warmup", 32'(bus.warmup_out), 32'd0);
`ifdef SAD_COST_OUT_EN
        check_val("rst_cost", 32'(bus.cost_out), 32'd0);
`endif
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.data_valid_out) pulses++;
            tick();
        end
        check_val("rst_ignored_pulses", 32'(pulses), 32'd0);
        check_val("rst_idle_ready", 32'(bus.ready_out), 32'd1);

        // Flat scene: every candidate costs 0, so d=0 wins.
        for (int x = 0; x < 20; x++) begin
            send_col(flat_col(8'd100), flat_col(8'd100), x, 0);
            check_val("flat_line", 32'(res_line), 32'd0);
            check_val("flat_warmup", 32'(res_warm), 32'(x < 12));
            check_val("flat_hcount", 32'(res_h), 32'(x));
`ifdef SAD_COST_OUT_EN
            check_val("flat_cost", 32'(res_cost), 32'd0);
`endif
        end

        // Right image is the left image shifted by 4 columns.
        for (int x = 0; x < 20; x++) begin
            send_col(tex_col(x), tex_col(x + 4), x, 0);
            check_val("shift_warmup", 32'(res_warm), 32'(x < 12));
            if (x >= 12) begin
                check_val("shift_line", 32'(res_line), 32'd102);
`ifdef SAD_COST_OUT_EN
                check_val("shift_cost", 32'(res_cost), 32'd0);
`endif
            end
        end

        // Row restart after the textured row: history is zero, so d=1 (cost 30) beats d=0 (cost 570).
        send_col(flat_col(8'd10), flat_col(8'd200), 0, 1);
        check_val("restart_warmup", 32'(res_warm), 32'd1);
        check_val("restart_hcount", 32'(res_h), 32'd0);
        check_val("restart_vcount", 32'(res_v), 32'd1);
        check_val("restart_line", 32'(res_line), 32'd25);
`ifdef SAD_COST_OUT_EN
        check_val("restart_cost", 32'(res_cost), 32'd30);
`endif

        // Latency and handshake: accept at T, pulse at T+12, ready back at T+13, offer at T+5 dropped.
        wait_ready();
        bus.left_data_in  = flat_col(8'd77);
        bus.right_data_in = flat_col(8'd77);
        bus.hcount_in     = 10'd0;
        bus.vcount_in     = 9'd2;
        bus.data_valid_in = 1'b1;
        tick();
        for (int k = 1; k <= 13; k++) begin
            if (k == 5) begin
                bus.hcount_in     = 10'd99;
                bus.data_valid_in = 1'b1;
            end else begin
                bus.data_valid_in = 1'b0;
            end
            check_val("lat_ready", 32'(bus.ready_out), 32'(k == 13));
            check_val("lat_valid", 32'(bus.data_valid_out), 32'(k == 12));
            if (k < 13) tick();
        end
        check_val("lat_hcount_held", 32'(bus.hcount_out), 32'd0);
        check_val("lat_vcount_held", 32'(bus.vcount_out), 32'd2);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.data_valid_out) pulses++;
        end
        check_val("lat_dropped_pulses", 32'(pulses), 32'd0);
        check_val("lat_idle_ready", 32'(bus.ready_out), 32'd1);

        // Reset at T+6 aborts the search with no pulse.
        wait_ready();
        bus.left_data_in  = tex_col(3);
        bus.right_data_in = tex_col(7);
        bus.hcount_in     = 10'd3;
        bus.vcount_in     = 9'd3;
        bus.data_valid_in = 1'b1;
        tick();
        bus.data_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            if (bus.data_valid_out) pulses++;
            tick();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (bus.data_valid_out) pulses++;
            tick();
        end
        check_val("midrst_pulses", 32'(pulses), 32'd0);
        check_val("midrst_ready", 32'(bus.ready_out), 32'd1);

        // First accept after reset behaves as a row start even with hcount 5.
        send_col(flat_col(8'd10), flat_col(8'd200), 5, 4);
        check_val("postrst_line", 32'(res_line), 32'd25);
        check_val("postrst_warmup", 32'(res_warm), 32'd1);
        check_val("postrst_hcount", 32'(res_h), 32'd5);
        check_val("postrst_vcount", 32'(res_v), 32'd4);
`ifdef SAD_COST_OUT_EN
        check_val("postrst_cost", 32'(res_cost), 32'd30);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
